// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, monitor FSM state type and counter helpers.
// Used by the sync monitor and the VGA generator.
package vga_timing_pkg;

    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned V_TOTAL      = 521;
    localparam int unsigned H_PULSE      = 96;
    localparam int unsigned V_PULSE      = 2;
    localparam int unsigned H_BP         = 144;
    localparam int unsigned H_FP         = 784;
    localparam int unsigned V_BP         = 31;
    localparam int unsigned V_FP         = 511;
    localparam int unsigned LOCK_DEFAULT = 2;

    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } mon_state_e;

    function automatic logic [9:0] sat_inc(input logic [9:0] val);
        return (val == CNT_MAX) ? val : val + 10'd1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Sync input register with falling/rising-edge detect and low-width measurement.
// Low width is counted in i_tick units: clocks for hsync, lines for vsync.
module vga_sync_edge
    import vga_timing_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sync,
    input  logic       i_tick,
    output logic       o_fall,
    output logic       o_rise,
    output logic [9:0] o_low_cnt
);

    logic       sync_q, sync_d;
    logic       prev_q, prev_d;
    logic [9:0] low_cnt_q, low_cnt_d;

    always_comb begin
        sync_d    = i_sync;
        prev_d    = sync_q;
        o_fall    = prev_q & ~sync_q;
        o_rise    = ~prev_q & sync_q;
        low_cnt_d = low_cnt_q;
        // The fall sample is the first low tick of the pulse.
        if (o_fall) begin
            low_cnt_d = 10'd1;
        end else if (!sync_q && i_tick) begin
            low_cnt_d = sat_inc(low_cnt_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q    <= 1'b1;
            prev_q    <= 1'b1;
            low_cnt_q <= '0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            low_cnt_q <= low_cnt_d;
        end
    end

    assign o_low_cnt = low_cnt_q;

endmodule

// File: rtl/vga_sync_monitor.sv
// VGA sync monitor: recovers x/y/de from hsync/vsync, checks timing and locks after clean frames.
// Optional per-frame pixel checksum when VGA_MON_CHECKSUM_EN is defined.
module vga_sync_monitor
    import vga_timing_pkg::*;
#(
    parameter int unsigned HPIXELS     = H_TOTAL,
    parameter int unsigned VLINES      = V_TOTAL,
    parameter int unsigned HPULSE      = H_PULSE,
    parameter int unsigned VPULSE      = V_PULSE,
    parameter int unsigned HBP         = H_BP,
    parameter int unsigned HFP         = H_FP,
    parameter int unsigned VBP         = V_BP,
    parameter int unsigned VFP         = V_FP,
    parameter int unsigned LOCK_FRAMES = LOCK_DEFAULT
) (
    input  logic        i_pixclk,
    input  logic        i_rst_n,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [2:0]  i_red,
    input  logic [2:0]  i_green,
    input  logic [1:0]  i_blue,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic        o_de,
    output logic [7:0]  o_pixel,
    output logic        o_locked,
    output logic        o_frame_start,
    output logic        o_err_h,
    output logic        o_err_v,
    output logic [7:0]  o_err_count,
    output logic [15:0] o_frame_sum
);

    localparam logic [9:0] H_LAST   = 10'(HPIXELS - 1);
    localparam logic [9:0] V_LAST   = 10'(VLINES - 1);
    localparam logic [9:0] H_PW     = 10'(HPULSE);
    localparam logic [9:0] V_PW     = 10'(VPULSE);
    localparam logic [9:0] X_LO     = 10'(HBP);
    localparam logic [9:0] X_HI     = 10'(HFP);
    localparam logic [9:0] Y_LO     = 10'(VBP);
    localparam logic [9:0] Y_HI     = 10'(VFP);
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_FRAMES - 1);

    logic       hs_fall, hs_rise, vs_fall, vs_rise;
    logic [9:0] hs_low_cnt, vs_low_cnt;

    vga_sync_edge u_hs_edge (
        .i_clk     (i_pixclk),
        .i_rst_n   (i_rst_n),
        .i_sync    (i_hsync),
        .i_tick    (1'b1),
        .o_fall    (hs_fall),
        .o_rise    (hs_rise),
        .o_low_cnt (hs_low_cnt)
    );

    vga_sync_edge u_vs_edge (
        .i_clk     (i_pixclk),
        .i_rst_n   (i_rst_n),
        .i_sync    (i_vsync),
        .i_tick    (hs_fall),
        .o_fall    (vs_fall),
        .o_rise    (vs_rise),
        .o_low_cnt (vs_low_cnt)
    );

    mon_state_e state_q, state_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic [7:0] rgb_q, rgb_d;
    logic [7:0] pix_q, pix_d;
    logic [7:0] good_q, good_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] err_count_q, err_count_d;

    logic active;
    logic h_err_raw, v_err_raw, err_any;

    // Position counters and pixel pipeline: pix_q lines up with h_cnt_q/v_cnt_q.
    always_comb begin
        rgb_d   = {i_red, i_green, i_blue};
        pix_d   = rgb_q;
        h_cnt_d = hs_fall ? 10'd0 : sat_inc(h_cnt_q);
        v_cnt_d = v_cnt_q;
        if (hs_fall) begin
            v_cnt_d = vs_fall ? 10'd0 : sat_inc(v_cnt_q);
        end
    end

    // Timing checks; the timeout fires once, on the step into saturation.
    always_comb begin
        active    = (state_q != SEARCH);
        h_err_raw = (hs_fall && (h_cnt_q != H_LAST))
                  || (hs_rise && (hs_low_cnt != H_PW))
                  || (!hs_fall && (h_cnt_q == CNT_MAX - 10'd1));
        v_err_raw = (vs_fall && ((v_cnt_q != V_LAST) || !hs_fall))
                  || (vs_rise && (vs_low_cnt != V_PW));
        o_err_h       = active & h_err_raw;
        o_err_v       = active & v_err_raw;
        o_frame_start = active & vs_fall;
        err_any       = o_err_h | o_err_v;
    end

    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        frame_err_d = frame_err_q;
        err_count_d = err_count_q;
        if (err_any && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
        unique case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_d     = ACQUIRE;
                    good_d      = '0;
                    frame_err_d = 1'b0;
                end
            end
            ACQUIRE: begin
                if (vs_fall) begin
                    frame_err_d = 1'b0;
                    // An error on the boundary clock beats the lock.
                    if (err_any || frame_err_q) begin
                        good_d = '0;
                    end else if (good_q >= LOCK_LAST) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + 8'd1;
                    end
                end else if (err_any) begin
                    good_d      = '0;
                    frame_err_d = 1'b1;
                end
            end
            LOCKED: begin
                if (err_any) begin
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= SEARCH;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            rgb_q       <= '0;
            pix_q       <= '0;
            good_q      <= '0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            rgb_q       <= rgb_d;
            pix_q       <= pix_d;
            good_q      <= good_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        o_x         = h_cnt_q;
        o_y         = v_cnt_q;
        o_locked    = (state_q == LOCKED);
        o_err_count = err_count_q;
        o_de        = o_locked && (h_cnt_q >= X_LO) && (h_cnt_q < X_HI)
                      && (v_cnt_q >= Y_LO) && (v_cnt_q < Y_HI);
        o_pixel     = o_de ? pix_q : 8'h00;
    end

`ifdef VGA_MON_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] sum_q, sum_d;

    always_comb begin
        acc_d = acc_q;
        sum_d = sum_q;
        if (vs_fall) begin
            sum_d = acc_q;
            acc_d = '0;
        end else if (o_de) begin
            acc_d = acc_q + {8'h00, o_pixel};
        end
    end

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    assign o_frame_sum = sum_q;
`else
    assign o_frame_sum = 16'h0000;
`endif

endmodule
